// File: rtl/vector_exec_sequencer_if.sv
// rtl/vector_exec_sequencer_if.sv - operation/result handshake bundle for vector_exec_sequencer
interface vector_exec_sequencer_if #(
  parameter int DATA_WIDTH     = 19,
  parameter int VECTOR_SIZE    = 8,
  parameter int ALU_CTRL_WIDTH = 3
);
  logic                              inValid;
  logic                              inReady;
  logic [ALU_CTRL_WIDTH-1:0]         aluControl;
  logic                              scalarB;
  logic [VECTOR_SIZE*DATA_WIDTH-1:0] operandA;
  logic [VECTOR_SIZE*DATA_WIDTH-1:0] operandB;
  logic                              flush;
  logic                              outValid;
  logic                              outReady;
  logic [VECTOR_SIZE*DATA_WIDTH-1:0] result;
  logic [VECTOR_SIZE-1:0]            compareMask;
  logic                              busy;

  modport master (
    output inValid, aluControl, scalarB, operandA, operandB, flush, outReady,
    input  inReady, outValid, result, compareMask, busy
  );

  modport slave (
    input  inValid, aluControl, scalarB, operandA, operandB, flush, outReady,
    output inReady, outValid, result, compareMask, busy
  );
endinterface

// File: rtl/vector_exec_sequencer.sv
// rtl/vector_exec_sequencer.sv - multi-cycle fixed-point vector ALU, LANES lanes per beat
// Define VEXEC_SATURATE_EN to clamp add/sub/mul results; otherwise they wrap.
module vector_exec_sequencer #(
  parameter int DATA_WIDTH     = 19,
  parameter int FRAC_WIDTH     = 11,
  parameter int VECTOR_SIZE    = 8,
  parameter int LANES          = 2,
  parameter int ALU_CTRL_WIDTH = 3
) (
  input logic                clock,
  input logic                reset,
  vector_exec_sequencer_if.slave bus
);
  localparam int N  = VECTOR_SIZE / LANES;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = DATA_WIDTH;
  localparam int VW = VECTOR_SIZE * DATA_WIDTH;

  localparam logic [ALU_CTRL_WIDTH-1:0] OP_ADD = ALU_CTRL_WIDTH'(0);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SUB = ALU_CTRL_WIDTH'(1);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_AND = ALU_CTRL_WIDTH'(2);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_OR  = ALU_CTRL_WIDTH'(3);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_XOR = ALU_CTRL_WIDTH'(4);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_MUL = ALU_CTRL_WIDTH'(5);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_MIN = ALU_CTRL_WIDTH'(6);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_CMP = ALU_CTRL_WIDTH'(7);

  localparam logic [DW-1:0]         ONE       = DW'(1) << FRAC_WIDTH;
  localparam logic [BW-1:0]         LAST_BEAT = BW'(N - 1);
`ifdef VEXEC_SATURATE_EN
  localparam logic signed [2*DW-1:0] SAT_MAX_W = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW-1:0] SAT_MIN_W = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]          SAT_MAX   = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]          SAT_MIN   = {1'b1, {(DW-1){1'b0}}};
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [BW-1:0]             r_beat;
  logic [VW-1:0]             r_a;
  logic [VW-1:0]             r_b;
  logic [VW-1:0]             r_result;
  logic [VECTOR_SIZE-1:0]    r_mask;
  logic [ALU_CTRL_WIDTH-1:0] r_op;
  logic [VW-1:0]             w_b_in;
  logic [LANES*DW-1:0]       w_beat_res;
  logic [LANES-1:0]          w_beat_lt;
  logic                      w_last;

  // Wide intermediate narrowed to one lane: clamp or keep the low bits.
  function automatic logic [DW-1:0] narrow(input logic signed [2*DW-1:0] v);
`ifdef VEXEC_SATURATE_EN
    if (v > SAT_MAX_W)      return SAT_MAX;
    else if (v < SAT_MIN_W) return SAT_MIN;
    else                    return v[DW-1:0];
`else
    return v[DW-1:0];
`endif
  endfunction

  function automatic logic [DW-1:0] lane_alu(input logic [ALU_CTRL_WIDTH-1:0] op,
                                             input logic signed [DW-1:0] a,
                                             input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] ax;
    logic signed [2*DW-1:0] bx;
    logic signed [2*DW-1:0] prod;
    ax   = a;
    bx   = b;
    prod = (ax * bx) >>> FRAC_WIDTH;
    case (op)
      OP_ADD:  return narrow(ax + bx);
      OP_SUB:  return narrow(ax - bx);
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_MUL:  return narrow(prod);
      OP_MIN:  return (a < b) ? a : b;
      OP_CMP:  return (a < b) ? ONE : '0;
      default: return '0;
    endcase
  endfunction

  assign w_last = (r_beat == LAST_BEAT);

  always_comb begin
    w_b_in = '0;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      w_b_in[i*DW +: DW] = bus.scalarB ? bus.operandB[DW-1:0] : bus.operandB[i*DW +: DW];
    end
  end

  // Lanes of the current beat, selected by the beat counter.
  always_comb begin
    w_beat_res = '0;
    w_beat_lt  = '0;
    for (int j = 0; j < LANES; j++) begin
      int idx;
      idx = int'(r_beat) * LANES + j;
      w_beat_res[j*DW +: DW] = lane_alu(r_op, r_a[idx*DW +: DW], r_b[idx*DW +: DW]);
      w_beat_lt[j] = (r_op == OP_CMP) &&
                     ($signed(r_a[idx*DW +: DW]) < $signed(r_b[idx*DW +: DW]));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.inValid)  w_next = S_RUN;
      S_RUN:   if (w_last)       w_next = S_DONE;
      S_DONE:  if (bus.outReady) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (bus.flush) w_next = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_beat   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_mask   <= '0;
    end else if (bus.flush) begin
      r_beat <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.inValid) begin
            r_a      <= bus.operandA;
            r_b      <= w_b_in;
            r_op     <= bus.aluControl;
            r_beat   <= '0;
            r_result <= '0;
            r_mask   <= '0;
          end
        end
        S_RUN: begin
          for (int j = 0; j < LANES; j++) begin
            r_result[(int'(r_beat)*LANES + j)*DW +: DW] <= w_beat_res[j*DW +: DW];
            r_mask[int'(r_beat)*LANES + j]              <= w_beat_lt[j];
          end
          r_beat <= w_last ? '0 : r_beat + BW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.inReady     = (r_state == S_IDLE);
  assign bus.outValid    = (r_state == S_DONE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.result      = r_result;
  assign bus.compareMask = r_mask;
endmodule

// File: tb/tb_vector_exec_sequencer.sv
// tb/tb_vector_exec_sequencer.sv - directed self-checking bench for vector_exec_sequencer
module tb_vector_exec_sequencer;
  localparam int DW = 19;
  localparam int VS = 8;
  localparam int VW = DW * VS;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  vector_exec_sequencer_if #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .ALU_CTRL_WIDTH(3)) bus ();

  vector_exec_sequencer #(
    .DATA_WIDTH(DW), .FRAC_WIDTH(11), .VECTOR_SIZE(VS), .LANES(2), .ALU_CTRL_WIDTH(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  function automatic logic [VW-1:0] fill(input logic [DW-1:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < VS; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic accept(input logic [2:0] op, input logic [VW-1:0] a,
                        input logic [VW-1:0] b, input logic sb);
    bus.aluControl = op;
    bus.operandA   = a;
    bus.operandB   = b;
    bus.scalarB    = sb;
    bus.inValid    = 1'b1;
    tick();
    bus.inValid    = 1'b0;
    bus.operandA   = '0;
    bus.operandB   = '0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 1;
    while (!bus.outValid && cycles < 50) begin
      tick();
      cycles++;
    end
  endtask

  task automatic drain;
    bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    n_tests++;
    if (bus.inReady !== 1'b1 || bus.outValid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got inReady=%b outValid=%b busy=%b, want 1 0 0",
               bus.inReady, bus.outValid, bus.busy);
    end
    n_tests++;
    if (bus.result !== '0 || bus.compareMask !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got result=%h mask=%h, want 0 0", bus.result, bus.compareMask);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_add;
    int cyc;
    accept(3'b000, fill(19'd2048), fill(19'd1024), 1'b0);
    wait_done(cyc);
    n_tests++;
    if (cyc !== 5) begin
      n_fail++;
      $display("FAIL add_latency: got %0d cycles, want 5", cyc);
    end
    n_tests++;
    if (bus.result !== fill(19'd3072) || bus.compareMask !== 8'h00) begin
      n_fail++;
      $display("FAIL add_result: got %h mask=%h, want %h mask=00",
               bus.result, bus.compareMask, fill(19'd3072));
    end
    drain();
  endtask

  task automatic test_overflow;
    int cyc;
    logic [DW-1:0] exp_lane;
`ifdef VEXEC_SATURATE_EN
    exp_lane = 19'h3FFFF;
`else
    exp_lane = 19'h40000;
`endif
    accept(3'b000, fill(19'h3FFFF), fill(19'd1), 1'b0);
    wait_done(cyc);
    n_tests++;
    if (bus.result !== fill(exp_lane)) begin
      n_fail++;
      $display("FAIL overflow: got %h, want %h", bus.result, fill(exp_lane));
    end
    drain();
  endtask

  task automatic test_mul_broadcast;
    int cyc;
    logic [VW-1:0] b;
    b = fill(19'd5);
    b[DW-1:0] = 19'h7FC00;
    accept(3'b101, fill(19'd6144), b, 1'b1);
    wait_done(cyc);
    n_tests++;
    if (bus.result !== fill(19'h7F400)) begin
      n_fail++;
      $display("FAIL mul_broadcast: got %h, want %h", bus.result, fill(19'h7F400));
    end
    drain();
  endtask

  task automatic test_compare;
    int cyc;
    logic [VW-1:0] a;
    logic [VW-1:0] exp_r;
    for (int i = 0; i < VS; i++) begin
      a[i*DW +: DW]     = DW'(i);
      exp_r[i*DW +: DW] = (i < 4) ? 19'd2048 : 19'd0;
    end
    accept(3'b111, a, fill(19'd4), 1'b0);
    wait_done(cyc);
    n_tests++;
    if (bus.compareMask !== 8'h0F) begin
      n_fail++;
      $display("FAIL compare_mask: got %h, want 0f", bus.compareMask);
    end
    n_tests++;
    if (bus.result !== exp_r) begin
      n_fail++;
      $display("FAIL compare_result: got %h, want %h", bus.result, exp_r);
    end
    drain();
  endtask

  task automatic test_ops;
    logic [2:0]    ops  [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
    logic [DW-1:0] exps [6] = '{19'h00113, 19'h00133, 19'h00120, 19'h7FFF3, 19'h7FED3, 19'h7FFF0};
    int cyc;
    for (int k = 0; k < 6; k++) begin
      accept(ops[k], fill(19'h00123), fill(19'h7FFF0), 1'b0);
      wait_done(cyc);
      n_tests++;
      if (bus.result !== fill(exps[k]) || bus.compareMask !== 8'h00) begin
        n_fail++;
        $display("FAIL op_%b: got %h mask=%h, want %h mask=00",
                 ops[k], bus.result, bus.compareMask, fill(exps[k]));
      end
      drain();
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    accept(3'b000, fill(19'd100), fill(19'd23), 1'b0);
    wait_done(cyc);
    for (int c = 0; c < 10; c++) begin
      bus.inValid    = (c == 3);
      bus.aluControl = 3'b001;
      bus.operandA   = fill(19'd7);
      tick();
      n_tests++;
      if (bus.outValid !== 1'b1 || bus.inReady !== 1'b0 || bus.result !== fill(19'd123)) begin
        n_fail++;
        $display("FAIL backpressure_hold%0d: got outValid=%b inReady=%b result=%h, want 1 0 %h",
                 c, bus.outValid, bus.inReady, bus.result, fill(19'd123));
      end
    end
    bus.inValid = 1'b0;
    drain();
    n_tests++;
    if (bus.inReady !== 1'b1 || bus.outValid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: got inReady=%b outValid=%b, want 1 0",
               bus.inReady, bus.outValid);
    end
    tick();
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_nocapture: got busy=%b, want 0", bus.busy);
    end
  endtask

  task automatic test_flush;
    int cyc;
    logic [VW-1:0] exp_r;
    exp_r = '0;
    exp_r[0 +: DW]  = 19'd3072;
    exp_r[DW +: DW] = 19'd3072;
    accept(3'b000, fill(19'd2048), fill(19'd1024), 1'b0);
    tick();
    n_tests++;
    if (bus.outValid !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre: got outValid=%b busy=%b, want 0 1", bus.outValid, bus.busy);
    end
    bus.flush    = 1'b1;
    bus.outReady = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.outReady = 1'b0;
    n_tests++;
    if (bus.inReady !== 1'b1 || bus.outValid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: got inReady=%b outValid=%b busy=%b, want 1 0 0",
               bus.inReady, bus.outValid, bus.busy);
    end
    n_tests++;
    if (bus.result !== exp_r) begin
      n_fail++;
      $display("FAIL flush_keep: got %h, want %h", bus.result, exp_r);
    end
    accept(3'b001, fill(19'd2048), fill(19'd1024), 1'b0);
    wait_done(cyc);
    n_tests++;
    if (cyc !== 5 || bus.result !== fill(19'd1024)) begin
      n_fail++;
      $display("FAIL flush_next: got %0d cycles result=%h, want 5 %h",
               cyc, bus.result, fill(19'd1024));
    end
    drain();
  endtask

  task automatic test_reset_midrun;
    int seen;
    accept(3'b000, fill(19'd2048), fill(19'd1024), 1'b0);
    tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if (bus.inReady !== 1'b1 || bus.outValid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.result !== '0 || bus.compareMask !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_midrun: got inReady=%b outValid=%b busy=%b result=%h mask=%h, want 1 0 0 0 0",
               bus.inReady, bus.outValid, bus.busy, bus.result, bus.compareMask);
    end
    @(negedge clock);
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.outValid) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_discard: got %0d outValid cycles, want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    int k;
    int cyc;
    bus.outReady   = 1'b1;
    bus.aluControl = 3'b011;
    bus.operandA   = fill(19'h00F00);
    bus.operandB   = fill(19'h0000F);
    bus.scalarB    = 1'b0;
    bus.inValid    = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!bus.inReady && k < 20);
    bus.inValid = 1'b0;
    n_tests++;
    if (k !== 6) begin
      n_fail++;
      $display("FAIL back_to_back_interval: got %0d cycles, want 6", k);
    end
    tick();
    wait_done(cyc);
    n_tests++;
    if (bus.result !== fill(19'h00F0F)) begin
      n_fail++;
      $display("FAIL back_to_back_result: got %h, want %h", bus.result, fill(19'h00F0F));
    end
    tick();
    bus.outReady = 1'b0;
  endtask

  initial begin
    bus.inValid    = 1'b0;
    bus.aluControl = '0;
    bus.scalarB    = 1'b0;
    bus.operandA   = '0;
    bus.operandB   = '0;
    bus.flush      = 1'b0;
    bus.outReady   = 1'b0;
    #2;
    test_reset();
    test_add();
    test_overflow();
    test_mul_broadcast();
    test_compare();
    test_ops();
    test_backpressure();
    test_flush();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
